// File: rtl/pid_cfg_seq.sv
// pid_cfg_seq -- configuration sequencer for one PID controller instance.
//
// Takes a new parameter set (set point, Kp, Ki, Kd) over a valid/ready
// handshake and applies it to the PID atomically. The set is applied either
// on the accept edge or, in triggered mode, on the first edge with trg high.
// After the set is applied, two optional steps can run:
//   - an integrator-clear pulse of IRC cycles, and
//   - a linear set-point ramp toward the new target.
// abort cancels a sequence in progress. When aborted, the outputs keep their
// current values and no completion event is raised.
//
// Ports:
//   clk, rstn          clock; asynchronous active-low reset
//   cfg_vld / cfg_rdy  parameter-set handshake (cfg_rdy = idle && !abort)
//   cfg_sp/kp/ki/kd    new target set point and gains (signed)
//   cfg_irst           clear the integrator as part of this update
//   cfg_ramp           ramp the set point rather than jump to it
//   ramp_step          unsigned per-cycle ramp increment
//   trg_mode           0 = apply on accept, 1 = wait for trg
//   trg                apply trigger (level-sampled)
//   abort              cancel the sequence in progress
//   set_sp/kp/ki/kd    registered values driven to the PID
//   int_rst            integrator reset to the PID
//   busy               sequence in progress
//   evt_done           one-cycle pulse after a sequence completes
module pid_cfg_seq #(
   parameter int DWI = 14,
   parameter int KW  = 14,
   parameter int IRC = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  cfg_vld,
   output logic                  cfg_rdy,
   input  logic signed [DWI-1:0] cfg_sp,
   input  logic signed [KW-1:0]  cfg_kp,
   input  logic signed [KW-1:0]  cfg_ki,
   input  logic signed [KW-1:0]  cfg_kd,
   input  logic                  cfg_irst,
   input  logic                  cfg_ramp,
   input  logic [DWI-1:0]        ramp_step,
   input  logic                  trg_mode,
   input  logic                  trg,
   input  logic                  abort,
   output logic signed [DWI-1:0] set_sp,
   output logic signed [KW-1:0]  set_kp,
   output logic signed [KW-1:0]  set_ki,
   output logic signed [KW-1:0]  set_kd,
   output logic                  int_rst,
   output logic                  busy,
   output logic                  evt_done
);

   localparam int CW = (IRC > 1) ? $clog2(IRC) : 1;

   typedef enum logic [1:0] {IDLE, ARM, CLR, RAMP} state_t;

   state_t                state_reg, state_next;
   logic [CW-1:0]         cnt_reg, cnt_next;
   logic signed [DWI-1:0] tgt_reg, tgt_next;
   logic signed [KW-1:0]  kp_sh_reg, kp_sh_next;
   logic signed [KW-1:0]  ki_sh_reg, ki_sh_next;
   logic signed [KW-1:0]  kd_sh_reg, kd_sh_next;
   logic                  irst_sh_reg, irst_sh_next;
   logic                  ramp_sh_reg, ramp_sh_next;
   logic [DWI-1:0]        step_sh_reg, step_sh_next;
   logic signed [DWI-1:0] set_sp_reg, set_sp_next;
   logic signed [KW-1:0]  set_kp_reg, set_kp_next;
   logic signed [KW-1:0]  set_ki_reg, set_ki_next;
   logic signed [KW-1:0]  set_kd_reg, set_kd_next;
   logic                  int_rst_reg, int_rst_next;
   logic                  evt_done_reg, evt_done_next;

   // The apply source is the live inputs when applying on the accept edge
   // itself (the shadow is only being loaded on that same edge). Otherwise
   // the source is the shadow.
   logic                  from_in;
   logic signed [DWI-1:0] src_sp;
   logic signed [KW-1:0]  src_kp, src_ki, src_kd;
   logic                  src_irst, src_ramp;
   logic [DWI-1:0]        src_step;

   assign from_in  = (state_reg == IDLE);
   assign src_sp   = from_in ? cfg_sp    : tgt_reg;
   assign src_kp   = from_in ? cfg_kp    : kp_sh_reg;
   assign src_ki   = from_in ? cfg_ki    : ki_sh_reg;
   assign src_kd   = from_in ? cfg_kd    : kd_sh_reg;
   assign src_irst = from_in ? cfg_irst  : irst_sh_reg;
   assign src_ramp = from_in ? cfg_ramp  : ramp_sh_reg;
   assign src_step = from_in ? ramp_step : step_sh_reg;

   // Ramp arithmetic uses one extra bit. With that bit the difference and its
   // magnitude cannot overflow. A step is taken only while |d| > step, so the
   // stepped value always lies strictly between set_sp and the target. As a
   // result, truncating it back to DWI bits never wraps.
   logic signed [DWI:0] diff;
   logic [DWI:0]        mag;
   logic [DWI:0]        sp_ext, step_ext, sp_step;

   assign diff     = {tgt_reg[DWI-1], tgt_reg} - {set_sp_reg[DWI-1], set_sp_reg};
   assign mag      = diff[DWI] ? (~diff + 1'b1) : diff;
   assign sp_ext   = {set_sp_reg[DWI-1], set_sp_reg};
   assign step_ext = {1'b0, step_sh_reg};
   assign sp_step  = diff[DWI] ? (sp_ext - step_ext) : (sp_ext + step_ext);

   logic accept, apply;

   assign cfg_rdy = (state_reg == IDLE) && !abort;
   assign accept  = cfg_vld && cfg_rdy;

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      tgt_next      = tgt_reg;
      kp_sh_next    = kp_sh_reg;
      ki_sh_next    = ki_sh_reg;
      kd_sh_next    = kd_sh_reg;
      irst_sh_next  = irst_sh_reg;
      ramp_sh_next  = ramp_sh_reg;
      step_sh_next  = step_sh_reg;
      set_sp_next   = set_sp_reg;
      set_kp_next   = set_kp_reg;
      set_ki_next   = set_ki_reg;
      set_kd_next   = set_kd_reg;
      int_rst_next  = int_rst_reg;
      evt_done_next = 1'b0;
      apply         = 1'b0;

      case (state_reg)
         IDLE: begin
            if (accept) begin
               tgt_next     = cfg_sp;
               kp_sh_next   = cfg_kp;
               ki_sh_next   = cfg_ki;
               kd_sh_next   = cfg_kd;
               irst_sh_next = cfg_irst;
               ramp_sh_next = cfg_ramp;
               step_sh_next = ramp_step;
               if (trg_mode) state_next = ARM;
               else          apply      = 1'b1;
            end
         end
         ARM: begin
            if (abort)    state_next = IDLE;
            else if (trg) apply      = 1'b1;
         end
         CLR: begin
            if (abort) begin
               state_next   = IDLE;
               int_rst_next = 1'b0;
            end else if (cnt_reg == '0) begin
               int_rst_next = 1'b0;
               if (ramp_sh_reg && (step_sh_reg != '0)) begin
                  state_next = RAMP;
               end else begin
                  set_sp_next   = tgt_reg;
                  state_next    = IDLE;
                  evt_done_next = 1'b1;
               end
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         RAMP: begin
            if (abort) begin
               state_next = IDLE;
            end else if (mag <= step_ext) begin
               set_sp_next   = tgt_reg;
               state_next    = IDLE;
               evt_done_next = 1'b1;
            end else begin
               set_sp_next = sp_step[DWI-1:0];
            end
         end
         default: state_next = IDLE;
      endcase

      if (apply) begin
         set_kp_next = src_kp;
         set_ki_next = src_ki;
         set_kd_next = src_kd;
         if (src_irst) begin
            int_rst_next = 1'b1;
            cnt_next     = CW'(IRC - 1);
            state_next   = CLR;
         end else if (src_ramp && (src_step != '0)) begin
            state_next = RAMP;
         end else begin
            set_sp_next   = src_sp;
            state_next    = IDLE;
            evt_done_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         tgt_reg      <= '0;
         kp_sh_reg    <= '0;
         ki_sh_reg    <= '0;
         kd_sh_reg    <= '0;
         irst_sh_reg  <= 1'b0;
         ramp_sh_reg  <= 1'b0;
         step_sh_reg  <= '0;
         set_sp_reg   <= '0;
         set_kp_reg   <= '0;
         set_ki_reg   <= '0;
         set_kd_reg   <= '0;
         int_rst_reg  <= 1'b0;
         evt_done_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         tgt_reg      <= tgt_next;
         kp_sh_reg    <= kp_sh_next;
         ki_sh_reg    <= ki_sh_next;
         kd_sh_reg    <= kd_sh_next;
         irst_sh_reg  <= irst_sh_next;
         ramp_sh_reg  <= ramp_sh_next;
         step_sh_reg  <= step_sh_next;
         set_sp_reg   <= set_sp_next;
         set_kp_reg   <= set_kp_next;
         set_ki_reg   <= set_ki_next;
         set_kd_reg   <= set_kd_next;
         int_rst_reg  <= int_rst_next;
         evt_done_reg <= evt_done_next;
      end
   end

   assign set_sp   = set_sp_reg;
   assign set_kp   = set_kp_reg;
   assign set_ki   = set_ki_reg;
   assign set_kd   = set_kd_reg;
   assign int_rst  = int_rst_reg;
   assign evt_done = evt_done_reg;
   assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_pid_cfg_seq.sv
// tb_pid_cfg_seq -- directed self-checking bench for pid_cfg_seq.
// Inputs are driven 1 time unit after each rising edge. Outputs are checked
// at the same point, after the registers have settled.
module tb_pid_cfg_seq;
   localparam int DWI = 14;
   localparam int KW  = 14;
   localparam int IRC = 4;

   logic                  clk = 1'b0;
   logic                  rstn = 1'b1;
   logic                  cfg_vld = 1'b0;
   logic                  cfg_rdy;
   logic signed [DWI-1:0] cfg_sp = '0;
   logic signed [KW-1:0]  cfg_kp = '0;
   logic signed [KW-1:0]  cfg_ki = '0;
   logic signed [KW-1:0]  cfg_kd = '0;
   logic                  cfg_irst = 1'b0;
   logic                  cfg_ramp = 1'b0;
   logic [DWI-1:0]        ramp_step = '0;
   logic                  trg_mode = 1'b0;
   logic                  trg = 1'b0;
   logic                  abort = 1'b0;
   logic signed [DWI-1:0] set_sp;
   logic signed [KW-1:0]  set_kp, set_ki, set_kd;
   logic                  int_rst, busy, evt_done;

   int n_chk  = 0;
   int n_fail = 0;

   pid_cfg_seq #(.DWI(DWI), .KW(KW), .IRC(IRC)) dut (
      .clk(clk), .rstn(rstn), .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy),
      .cfg_sp(cfg_sp), .cfg_kp(cfg_kp), .cfg_ki(cfg_ki), .cfg_kd(cfg_kd),
      .cfg_irst(cfg_irst), .cfg_ramp(cfg_ramp), .ramp_step(ramp_step),
      .trg_mode(trg_mode), .trg(trg), .abort(abort),
      .set_sp(set_sp), .set_kp(set_kp), .set_ki(set_ki), .set_kd(set_kd),
      .int_rst(int_rst), .busy(busy), .evt_done(evt_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one parameter set for a single edge.
   task automatic send(input int sp, input int kp, input int ki, input int kd,
                       input logic irst, input logic ramp, input int step,
                       input logic mode);
      cfg_sp    = DWI'(sp);
      cfg_kp    = KW'(kp);
      cfg_ki    = KW'(ki);
      cfg_kd    = KW'(kd);
      cfg_irst  = irst;
      cfg_ramp  = ramp;
      ramp_step = DWI'(step);
      trg_mode  = mode;
      cfg_vld   = 1'b1;
      tick();
      cfg_vld   = 1'b0;
   endtask

   initial begin
      // Reset state
      #2 rstn = 1'b0;
      #1;
      chk("rst_set_sp", set_sp, 0);
      chk("rst_set_kp", set_kp, 0);
      chk("rst_int_rst", int_rst, 0);
      chk("rst_evt", evt_done, 0);
      chk("rst_busy", busy, 0);
      tick();
      tick();
      rstn = 1'b1;
      chk("rst_cfg_rdy", cfg_rdy, 1);

      // Immediate apply, with no clear and no ramp
      send(100, 'h0800, 3, -5, 0, 0, 0, 0);
      chk("imm_sp", set_sp, 100);
      chk("imm_kp", set_kp, 'h0800);
      chk("imm_ki", set_ki, 3);
      chk("imm_kd", set_kd, -5);
      chk("imm_evt", evt_done, 1);
      chk("imm_busy", busy, 0);
      tick();
      chk("imm_evt_off", evt_done, 0);
      chk("imm_busy2", busy, 0);

      // Ramp up: 0 -> 100, step 30
      send(0, 'h0800, 3, -5, 0, 0, 0, 0);
      chk("pre_up_sp", set_sp, 0);
      tick();
      send(100, 'h0800, 3, -5, 0, 1, 30, 0);
      chk("up_busy0", busy, 1);
      chk("up_sp0", set_sp, 0);
      chk("up_rdy0", cfg_rdy, 0);
      tick(); chk("up_sp1", set_sp, 30); chk("up_busy1", busy, 1);
      tick(); chk("up_sp2", set_sp, 60); chk("up_evt2", evt_done, 0);
      tick(); chk("up_sp3", set_sp, 90); chk("up_busy3", busy, 1);
      tick(); chk("up_sp4", set_sp, 100); chk("up_busy4", busy, 0);
      chk("up_evt4", evt_done, 1);
      tick(); chk("up_evt5", evt_done, 0);

      // Ramp down across the full range: 8191 -> -8192, step 8191
      send(8191, 'h0800, 3, -5, 0, 0, 0, 0);
      chk("pre_dn_sp", set_sp, 8191);
      tick();
      send(-8192, 'h0800, 3, -5, 0, 1, 8191, 0);
      chk("dn_sp0", set_sp, 8191);
      tick(); chk("dn_sp1", set_sp, 0);
      tick(); chk("dn_sp2", set_sp, -8191); chk("dn_evt2", evt_done, 0);
      tick(); chk("dn_sp3", set_sp, -8192); chk("dn_evt3", evt_done, 1);
      chk("dn_busy3", busy, 0);
      tick();

      // Armed with integrator clear. A trg on the accept edge is ignored.
      trg = 1'b1;
      send(-200, 'h123, 'h45, 'h67, 1, 0, 0, 1);
      trg = 1'b0;
      chk("arm_busy0", busy, 1);
      chk("arm_kp0", set_kp, 'h0800);
      chk("arm_irst0", int_rst, 0);
      for (int i = 0; i < 10; i++) tick();
      chk("arm_sp_hold", set_sp, -8192);
      chk("arm_kp_hold", set_kp, 'h0800);
      chk("arm_busy", busy, 1);
      chk("arm_rdy", cfg_rdy, 0);
      chk("arm_irst_hold", int_rst, 0);
      trg = 1'b1;
      tick();
      trg = 1'b0;
      chk("clr_kp", set_kp, 'h123);
      chk("clr_ki", set_ki, 'h45);
      chk("clr_kd", set_kd, 'h67);
      chk("clr_irst1", int_rst, 1);
      chk("clr_sp1", set_sp, -8192);
      tick(); chk("clr_irst2", int_rst, 1);
      tick(); chk("clr_irst3", int_rst, 1);
      tick(); chk("clr_irst4", int_rst, 1); chk("clr_evt4", evt_done, 0);
      tick(); chk("clr_irst5", int_rst, 0);
      chk("clr_sp5", set_sp, -200);
      chk("clr_evt5", evt_done, 1);
      chk("clr_busy5", busy, 0);
      tick();

      // Abort in the middle of a ramp
      send(0, 'h123, 'h45, 'h67, 0, 0, 0, 0);
      tick();
      send(1000, 'h123, 'h45, 'h67, 0, 1, 10, 0);
      for (int i = 0; i < 5; i++) tick();
      chk("ab_sp_pre", set_sp, 50);
      abort = 1'b1;
      tick();
      chk("ab_sp", set_sp, 50);
      chk("ab_busy", busy, 0);
      chk("ab_evt", evt_done, 0);
      chk("ab_rdy", cfg_rdy, 0);
      abort = 1'b0;
      #1;
      chk("ab_rdy_after", cfg_rdy, 1);
      tick();
      chk("ab_sp_hold", set_sp, 50);
      chk("ab_evt2", evt_done, 0);
      send(77, 'h123, 'h45, 'h67, 0, 0, 0, 0);
      chk("ab_new_sp", set_sp, 77);
      chk("ab_new_evt", evt_done, 1);
      tick();

      // Abort together with cfg_vld: the set is not accepted
      abort = 1'b1;
      #1;
      chk("abv_rdy", cfg_rdy, 0);
      send(555, 'h11, 'h22, 'h33, 0, 0, 0, 0);
      abort = 1'b0;
      chk("abv_sp", set_sp, 77);
      chk("abv_kp", set_kp, 'h123);
      chk("abv_evt", evt_done, 0);
      chk("abv_busy", busy, 0);
      tick();

      // Asynchronous reset in the middle of the clear step
      send(999, 'h0AA, 'h0BB, 'h0CC, 1, 0, 0, 0);
      chk("ar_irst", int_rst, 1);
      chk("ar_kp", set_kp, 'h0AA);
      tick();
      chk("ar_busy", busy, 1);
      #3 rstn = 1'b0;
      #1;
      chk("ar_irst0", int_rst, 0);
      chk("ar_sp0", set_sp, 0);
      chk("ar_kp0", set_kp, 0);
      chk("ar_busy0", busy, 0);
      tick();
      rstn = 1'b1;
      tick();
      chk("ar_rdy", cfg_rdy, 1);
      chk("ar_evt", evt_done, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pid_cfg_seq.md
Name: pid_cfg_seq

Overview:
Configuration sequencer for a single PID controller instance. It accepts a new parameter set (set point and Kp/Ki/Kd) over a valid/ready handshake, then applies it atomically, either immediately or on an external trigger. Optional steps are an integrator-clear pulse and a linear set-point ramp. It sits between the register bank and the PID block, driving the PID's set_sp/set_kp/set_ki/set_kd/int_rst inputs.

Parameters:
DWI, 14, data/set-point width (signed)
KW, 14, gain width (signed)
IRC, 4, integrator-reset pulse length in cycles (>=1)

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
cfg_vld  in  1  new parameter set valid
cfg_rdy  out  1  sequencer can accept a set
cfg_sp  in  DWI  target set point (signed)
cfg_kp  in  KW  Kp (signed)
cfg_ki  in  KW  Ki (signed)
cfg_kd  in  KW  Kd (signed)
cfg_irst  in  1  clear integrator as part of this update
cfg_ramp  in  1  ramp set point instead of jumping
ramp_step  in  DWI  unsigned per-cycle ramp increment; sampled at accept
trg_mode  in  1  0 = apply immediately on accept, 1 = wait for trg; sampled at accept
trg  in  1  apply trigger (level-sampled)
abort  in  1  cancel sequence in progress
set_sp  out  DWI  set point to PID
set_kp  out  KW  Kp to PID
set_ki  out  KW  Ki to PID
set_kd  out  KW  Kd to PID
int_rst  out  1  integrator reset to PID
busy  out  1  state != IDLE
evt_done  out  1  one-cycle pulse when a sequence completes

Behaviour:
- Clock is clk. Reset is asynchronous, active-low (rstn), as already decided. Reset values: set_* = 0, int_rst = 0, evt_done = 0, state = IDLE.
- cfg_rdy = (state==IDLE) && !abort. It is combinational, so it is 1 right after reset.
- Accept happens at an edge with cfg_vld && cfg_rdy. All cfg_* fields, ramp_step and trg_mode are latched into shadow registers at that edge.
- States are IDLE, ARM, CLR, RAMP.
- "Apply" at edge E:
  - set_kp/ki/kd are loaded from shadow at E.
  - If shadow irst: int_rst=1 from E; next state CLR; counter=IRC-1.
  - Else if ramp && step!=0: next state RAMP.
  - Else: set_sp=target at E; sequence completes at E.
- IDLE + accept: if trg_mode=0, apply at the accept edge (outputs visible the cycle after accept). If trg_mode=1, next state is ARM.
- ARM: apply at the first edge with trg=1. A trg coinciding with the accept edge is ignored.
- CLR: int_rst stays 1 for exactly IRC cycles, then deasserts. After that, go to RAMP if ramp && step!=0. Otherwise set_sp=target and the sequence completes.
- RAMP: at each edge, d = target - set_sp, computed in DWI+1 bits signed.
  - If |d| <= step: set_sp = target; complete.
  - Else: set_sp += sign(d)*step.
  - Never overshoots; never wraps.
  - Cycle count is ceil(|d0|/step).
- Complete at edge C: state = IDLE; evt_done = 1 for the cycle after C only. Immediate mode with no clear and no ramp pulses evt_done the cycle after accept, and busy stays 0.
- abort has priority over trg, the RAMP step and the CLR count. At the abort edge:
  - state = IDLE and int_rst = 0.
  - set_* hold their current values (a ramp stops mid-way).
  - The shadow is discarded and there is no evt_done.
- Async reset mid-sequence returns everything to reset values immediately.
- busy = (state != IDLE).

Test Plan:
- Immediate: trg_mode=0, sp=100, kp=0x0800, no irst/ramp, accept at edge N -> set_sp=100, set_kp=0x0800 from cycle N+1; evt_done pulses 1 cycle; busy never 1.
- Ramp up: set_sp=0, target 100, step 30 -> set_sp 30, 60, 90, 100 on consecutive edges; evt_done the cycle after 100 appears; busy high 4 cycles.
- Ramp down at extremes: set_sp=8191, target -8192, step 8191 -> 0, -8191, -8192; no wrap, no overshoot.
- Armed + clear: trg_mode=1, irst=1, IRC=4; trg held low 10 cycles -> set_* unchanged, busy=1, cfg_rdy=0. trg pulse -> gains load and int_rst high exactly 4 cycles, then set_sp=target and evt_done.
- Abort mid-ramp: target 1000, step 10, abort after 5 ramp edges -> set_sp holds 50, busy=0 next cycle, no evt_done; a new accept is then accepted.
- Abort with cfg_vld in the same cycle -> cfg_rdy=0, set not accepted. Async rstn low mid-CLR -> int_rst=0 and set_*=0 immediately.
